// File: rtl/viterbi_frame_scheduler.sv
// Frame scheduler in front of a restartable Viterbi decoder: takes one 16-bit coded frame,
// restarts the decoder on it, waits for the decoder's done edge (bounded by TIMEOUT), and
// hands the decoded byte downstream over a valid/ready handshake.
module viterbi_frame_scheduler #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s_valid,
  input  logic [15:0]      s_data,
  output logic             s_ready,
  output logic [15:0]      dec_data,
  output logic             dec_rst_n,
  output logic             dec_en,
  input  logic [7:0]       dec_out,
  input  logic             dec_done,
  output logic             m_valid,
  output logic [7:0]       m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             timeout_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] KICK = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;

  // Last wait-counter value before the frame is abandoned.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [15:0]      r_wait_cnt;
  logic             r_done_prev;
  logic [15:0]      r_dec_data;
  logic             r_m_valid;
  logic [7:0]       r_m_data;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_timeout_err;

  logic w_accept;
  logic w_done_edge;
  logic w_terminal;
  logic w_handshake;
  logic w_busy;

  assign w_busy      = (r_state == LOAD) || (r_state == KICK) || (r_state == WAIT);
  assign s_ready     = (r_state == IDLE) && en && !rst;
  assign w_accept    = s_valid && s_ready;
  // Edge needs a registered 0 followed by a live 1; a level high on WAIT entry is stale.
  assign w_done_edge = (r_state == WAIT) && dec_done && !r_done_prev;
  assign w_terminal  = (r_state == WAIT) && (r_wait_cnt == WAIT_LAST);
  assign w_handshake = (r_state == HOLD) && r_m_valid && m_ready;

  assign dec_en      = en && !rst && w_busy;
  // Restart pulse only in an enabled LOAD cycle; held low for the whole of reset.
  assign dec_rst_n   = !rst && !(en && (r_state == LOAD));
  assign dec_data    = r_dec_data;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign frame_cnt   = r_frame_cnt;
  assign timeout_err = r_timeout_err;

  // Frame sequencing: IDLE -> LOAD -> KICK -> WAIT -> HOLD/IDLE, frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (en) begin
      case (r_state)
        IDLE: if (w_accept) r_state <= LOAD;
        LOAD: r_state <= KICK;
        KICK: r_state <= WAIT;
        WAIT: begin
          if (w_done_edge) begin
            r_state <= HOLD;
          end else if (w_terminal) begin
            r_state <= IDLE;
          end
        end
        HOLD: if (w_handshake) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Wait counter and dec_done history; both restart with every decoder restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_done_prev <= 1'b0;
    end else if (en) begin
      if (r_state == LOAD) begin
        r_wait_cnt  <= '0;
        r_done_prev <= 1'b0;
      end else if (r_state == KICK) begin
        r_done_prev <= dec_done;
      end else if (r_state == WAIT) begin
        r_wait_cnt  <= r_wait_cnt + 16'd1;
        r_done_prev <= dec_done;
      end
    end
  end

  // Frame capture, decoded-byte register, completion counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_data    <= '0;
      r_m_valid     <= 1'b0;
      r_m_data      <= '0;
      r_frame_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else if (en) begin
      if (w_accept) begin
        r_dec_data <= s_data;
      end
      // A done edge on the terminal count still wins over the timeout.
      if (w_done_edge) begin
        r_m_data  <= dec_out;
        r_m_valid <= 1'b1;
      end else if (w_terminal) begin
        r_timeout_err <= 1'b1;
      end
      if (w_handshake) begin
        r_m_valid   <= 1'b0;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_viterbi_frame_scheduler.sv
// Randomized directed bench for viterbi_frame_scheduler. The main instance uses TIMEOUT=8,
// CNT_W=3; a second default-parameter instance covers the basic 10-cycle decoder frame.
module tb_viterbi_frame_scheduler;

  localparam int TMO   = 8;
  localparam int CW    = 3;
  localparam int STALL = 5;

  logic clk;
  logic rst, en, s_valid, m_ready;
  logic [15:0] s_data;
  logic s_ready, dec_rst_n, dec_en, dec_done, m_valid, timeout_err;
  logic [15:0] dec_data;
  logic [7:0] dec_out, m_data;
  logic [CW-1:0] frame_cnt;

  logic b_s_valid, b_m_ready, b_s_ready, b_dec_rst_n, b_dec_en, b_dec_done;
  logic b_m_valid, b_timeout_err;
  logic [15:0] b_dec_data;
  logic [7:0] b_dec_out, b_m_data;
  logic [12:0] b_frame_cnt;

  logic [15:0] dm_cnt, b_dm_cnt;
  int dm_lat;
  logic ovr_en, ovr_val;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_cnt = 0;
  logic exp_terr = 1'b0;

  viterbi_frame_scheduler #(.TIMEOUT(TMO), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dec_data(dec_data), .dec_rst_n(dec_rst_n), .dec_en(dec_en), .dec_out(dec_out),
    .dec_done(dec_done), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  viterbi_frame_scheduler u_dflt (
    .clk(clk), .rst(rst), .en(en), .s_valid(b_s_valid), .s_data(s_data), .s_ready(b_s_ready),
    .dec_data(b_dec_data), .dec_rst_n(b_dec_rst_n), .dec_en(b_dec_en), .dec_out(b_dec_out),
    .dec_done(b_dec_done), .m_valid(b_m_valid), .m_data(b_m_data), .m_ready(b_m_ready),
    .frame_cnt(b_frame_cnt), .timeout_err(b_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the decoder's output byte.
  function automatic logic [7:0] dec_f(input logic [15:0] x);
    return x[15:8] ^ x[7:0] ^ 8'h5A;
  endfunction

  // Decoder models: restart latches the frame, done rises after dm_lat enabled cycles.
  always @(posedge clk) begin
    if (!dec_rst_n) begin
      dm_cnt  <= '0;
      dec_out <= dec_f(dec_data);
    end else if (dec_en && dm_cnt != 16'hFFFF) begin
      dm_cnt <= dm_cnt + 16'd1;
    end
  end
  assign dec_done = ovr_en ? ovr_val : (int'(dm_cnt) >= dm_lat);

  always @(posedge clk) begin
    if (!b_dec_rst_n) begin
      b_dm_cnt  <= '0;
      b_dec_out <= dec_f(b_dec_data);
    end else if (b_dec_en && b_dm_cnt != 16'hFFFF) begin
      b_dm_cnt <= b_dm_cnt + 16'd1;
    end
  end
  assign b_dec_done = (b_dm_cnt >= 16'd10);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame on the main instance. Expected timing comes from the rules: m_valid at
  // accept+3+d when 1<=d<=TMO, else timeout_err at accept+3+TMO; an en stall inside
  // WAIT pushes that event out by STALL cycles. Stale mode holds done high until a
  // single low cycle at accept+6, so the first real edge is accept+7.
  task automatic run_frame(input logic [15:0] data, input int d, input int bp,
                           input bit stale, input int stall_s);
    bit ok;
    bit acc;
    int e_end;
    logic [7:0] exp_b;
    ok = stale || (d >= 1 && d <= TMO);
    if (stale) d = 5;
    e_end = (ok ? 3 + d : 3 + TMO) + ((stall_s != 0) ? STALL : 0);
    dm_lat = d;
    exp_b = dec_f(data);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = data;
      if (stale) begin
        ovr_en  = 1'b1;
        ovr_val = 1'b1;
      end
      #1;
      acc = s_ready;
    end
    chk("accept", acc, 1);
    for (int k = 1; k <= e_end; k++) begin
      @(negedge clk);
      en      = !(stall_s != 0 && k >= stall_s && k < stall_s + STALL);
      s_valid = (k < e_end) ? 1'($urandom) : 1'b0;
      s_data  = 16'($urandom);
      if (stale) ovr_val = (k != 6);
      if (k == e_end && ok) m_ready = (bp == 0);
      #1;
      chk("dec_rst_n", dec_rst_n, (k == 1) ? 0 : 1);
      chk("dec_data", dec_data, data);
      chk("dec_en", dec_en, en && (k < e_end));
      chk("m_valid", m_valid, ok && (k == e_end));
      chk("s_ready", s_ready, !ok && (k == e_end));
      chk("timeout_err", timeout_err, exp_terr || (!ok && k == e_end));
    end
    if (ok) begin
      chk("m_data", m_data, exp_b);
      for (int j = 1; j <= bp; j++) begin
        @(negedge clk);
        m_ready = (j == bp);
        s_valid = 1'($urandom);
        #1;
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, exp_b);
        chk("hold_s_ready", s_ready, 0);
      end
      @(negedge clk);
      m_ready = 1'b0;
      s_valid = 1'b0;
      ovr_en  = 1'b0;
      #1;
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      chk("post_valid", m_valid, 0);
      chk("frame_cnt", frame_cnt, exp_cnt);
      chk("post_s_ready", s_ready, 1);
    end else begin
      exp_terr = 1'b1;
    end
  endtask

  initial begin
    int d;
    int st;
    rst = 1'b1; en = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    b_s_valid = 1'b0; b_m_ready = 1'b1; ovr_en = 1'b0; ovr_val = 1'b0; dm_lat = 1000;

    // Reset values, then first cycle out of reset.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_dec_rst_n", dec_rst_n, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_dec_data", dec_data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_b_timeout", b_timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_s_ready", s_ready, 1);
    chk("rel_b_s_ready", b_s_ready, 1);

    // Basic frame on the default instance, decoder done 10 cycles after restart.
    @(negedge clk);
    b_s_valid = 1'b1;
    s_data = 16'hB3C2;
    #1;
    chk("b_accept", b_s_ready, 1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      b_s_valid = 1'b0;
      #1;
      chk("b_dec_rst_n", b_dec_rst_n, (k == 1) ? 0 : 1);
      chk("b_m_valid", b_m_valid, k == 13);
      if (k == 13) chk("b_m_data", b_m_data, dec_f(16'hB3C2));
    end
    chk("b_dec_data", b_dec_data, 16'hB3C2);
    chk("b_frame_cnt", b_frame_cnt, 1);
    chk("b_timeout", b_timeout_err, 0);

    // Nine frames: counter wraps 1..7,0,1; first two hit the latency boundaries.
    run_frame(16'($urandom), TMO, 0, 1'b0, 0);
    run_frame(16'($urandom), 1, 0, 1'b0, 0);
    for (int i = 0; i < 7; i++) run_frame(16'($urandom), $urandom_range(1, TMO), 0, 1'b0, 0);

    // Back-pressure, timeouts (never / one past the deadline), recovery, stale done.
    run_frame(16'h5AA5, 3, 20, 1'b0, 0);
    run_frame(16'h0F0F, 100, 0, 1'b0, 0);
    run_frame(16'h1357, TMO + 1, 0, 1'b0, 0);
    run_frame(16'hCAFE, 2, 0, 1'b0, 0);
    run_frame(16'hBEEF, 0, 1, 1'b1, 0);

    // en stalls inside WAIT: timeout deadline and done capture both slip by STALL.
    run_frame(16'h2468, 100, 0, 1'b0, 5);
    run_frame(16'h9ABC, 6, 0, 1'b0, 4);

    for (int i = 0; i < 20; i++) begin
      d  = $urandom_range(1, TMO + 2);
      st = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 2 + ((d < TMO) ? d : TMO)) : 0;
      run_frame(16'($urandom), d, $urandom_range(0, 3), 1'b0, st);
    end

    // Reset while in WAIT aborts the frame and clears everything.
    dm_lat = 50;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = 16'h1234;
    #1;
    chk("mr_accept", s_ready, 1);
    repeat (4) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_s_ready", s_ready, 0);
    chk("mr_dec_rst_n", dec_rst_n, 0);
    chk("mr_dec_en", dec_en, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_m_valid", m_valid, 0);
    chk("mr_m_data", m_data, 0);
    chk("mr_dec_data", dec_data, 0);
    chk("mr_frame_cnt", frame_cnt, 0);
    chk("mr_timeout", timeout_err, 0);
    chk("mr_s_ready_rel", s_ready, 1);
    chk("mr_dec_rst_n_rel", dec_rst_n, 1);
    exp_cnt  = 0;
    exp_terr = 1'b0;
    run_frame(16'h7777, 4, 1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
